// File: rtl/gpr_pkg.sv
// Shared GPR constants, the write-arbiter state type and the write request payload.
package gpr_pkg;

    localparam int unsigned GPR_AW  = 5;
    localparam int unsigned GPR_NUM = 32;
    localparam int unsigned XLEN    = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        logic              lock;
        logic [GPR_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } gpr_wr_req_t;

endpackage

// File: rtl/gpr_wr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// Round-robin GPR write-port arbiter with burst lock, registered regfile write and snapshot strobe.
// Optional per-requester grant/stall counters when GPR_WR_ARB_PERF_EN is defined.
module gpr_wr_arbiter
    import gpr_pkg::arb_state_e;
    import gpr_pkg::IDLE;
    import gpr_pkg::LOCKED;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned XLEN     = gpr_pkg::XLEN,
    parameter int unsigned AW       = gpr_pkg::GPR_AW,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*XLEN-1:0]     req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_wen,
    output logic [AW-1:0]            rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     snap_valid,
    output logic [$clog2(NREQ)-1:0]  last_grant,
    output logic                     busy
`ifdef GPR_WR_ARB_PERF_EN
    ,
    output logic [NREQ*32-1:0]       perf_grant_cnt,
    output logic [NREQ*32-1:0]       perf_stall_cnt
`endif
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   lock_owner_q, lock_owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic            rf_wen_q, rf_wen_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            snap_valid_q, snap_valid_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] owner_oh;
    logic            owner_hold;
    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;
    logic            sel_lock;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // A locked owner that drops valid falls back to round-robin in the same cycle.
    always_comb begin : grant_sel
        owner_oh               = '0;
        owner_oh[lock_owner_q] = 1'b1;
        owner_hold             = (state_q == LOCKED) && req_valid[lock_owner_q];
        gnt_oh                 = owner_hold ? owner_oh : pick_gnt;
        gnt_idx                = owner_hold ? lock_owner_q : pick_idx;
        xfer                   = owner_hold || pick_any;
        sel_addr               = '0;
        sel_data               = '0;
        sel_lock               = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
                sel_lock = req_lock[i];
            end
        end
    end

    assign req_ready = reset ? gnt_oh : '0;

    always_comb begin : next_state
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        snap_valid_d = rf_wen_q;

        if (!owner_hold) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end

        if (xfer) begin
            if (32'(gnt_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + IW'(1);
            end
            last_grant_d = gnt_idx;

            // Writes to x0 consume a grant but never reach the regfile.
            if (sel_addr != '0) begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = sel_addr;
                rf_wdata_d = sel_data;
            end

            if (owner_hold) begin
                if (!sel_lock || (32'(lock_cnt_q) + 1 >= LOCK_MAX)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end
            end else if (sel_lock && (LOCK_MAX > 1)) begin
                state_d      = LOCKED;
                lock_owner_d = gnt_idx;
                lock_cnt_d   = CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            last_grant_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign snap_valid = snap_valid_q;
    assign last_grant = last_grant_q;
    assign busy       = (state_q == LOCKED) || rf_wen_q;

`ifdef GPR_WR_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NREQ];
    logic [31:0] grant_cnt_d [NREQ];
    logic [31:0] stall_cnt_q [NREQ];
    logic [31:0] stall_cnt_d [NREQ];

    always_comb begin : perf_next
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i] + 32'(req_valid[i] && gnt_oh[i]);
            stall_cnt_d[i] = stall_cnt_q[i] + 32'(req_valid[i] && !gnt_oh[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    always_comb begin : perf_out
        perf_grant_cnt = '0;
        perf_stall_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            perf_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
            perf_stall_cnt[i*32 +: 32] = stall_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed table-driven bench for gpr_wr_arbiter plus hand sequences for reset and single-write cases.
module tb_gpr_wr_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;
    localparam int NROWS = 30;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_lock;
    logic [NREQ*AW-1:0]      req_addr;
    logic [NREQ*XLEN-1:0]    req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    rf_wen;
    logic [AW-1:0]           rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    snap_valid;
    logic [1:0]              last_grant;
    logic                    busy;
`ifdef GPR_WR_ARB_PERF_EN
    logic [NREQ*32-1:0]      perf_grant_cnt;
    logic [NREQ*32-1:0]      perf_stall_cnt;
`endif

    gpr_wr_arbiter #(
        .NREQ     (NREQ),
        .XLEN     (XLEN),
        .AW       (AW),
        .LOCK_MAX (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .snap_valid (snap_valid),
        .last_grant (last_grant),
        .busy       (busy)
`ifdef GPR_WR_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic [4:0] a0;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [2:0] rdy;
        logic       wen;
        logic [4:0] wa;
        logic       snap;
        logic [1:0] lg;
        logic       busy;
    } vec_t;

    vec_t        tv [NROWS];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_wdata = '0;

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [2:0] rdy, input logic wen, input logic [4:0] wa,
                                input logic snap, input logic [1:0] lg, input logic bsy);
        vec_t t;
        t.v = v; t.l = l; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.rdy = rdy; t.wen = wen; t.wa = wa; t.snap = snap; t.lg = lg; t.busy = bsy;
        return t;
    endfunction

    function automatic logic [63:0] dat(input int r, input int i);
        return {16'hC0DE, 8'(r), 8'(i), 32'h0BAD_F00D};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        vec_t       t;
        logic [4:0] wa;
        for (int r = lo; r <= hi; r++) begin
            t = tv[r];
            req_valid = t.v;
            req_lock  = t.l;
            req_addr  = {t.a2, t.a1, t.a0};
            req_data  = {dat(r, 2), dat(r, 1), dat(r, 0)};
            #4;
            chk($sformatf("r%0d ready", r), 64'(req_ready), 64'(t.rdy));
            chk($sformatf("r%0d wen", r), 64'(rf_wen), 64'(t.wen));
            chk($sformatf("r%0d snap", r), 64'(snap_valid), 64'(t.snap));
            chk($sformatf("r%0d last_grant", r), 64'(last_grant), 64'(t.lg));
            chk($sformatf("r%0d busy", r), 64'(busy), 64'(t.busy));
            if (t.wen) begin
                chk($sformatf("r%0d waddr", r), 64'(rf_waddr), 64'(t.wa));
                chk($sformatf("r%0d wdata", r), rf_wdata, exp_wdata);
            end
            for (int k = 0; k < 3; k++) begin
                if (t.rdy[k]) begin
                    wa = (k == 0) ? t.a0 : ((k == 1) ? t.a1 : t.a2);
                    if (wa != 5'd0) exp_wdata = dat(r, k);
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // Fairness: all valid, no lock, starting from reset pointer 0.
        for (int r = 0; r < 6; r++) begin
            tv[r] = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 3'b001 << (r % 3),
                       (r > 0), 5'((r + 2) % 3 + 1), (r > 1), 2'((r + 2) % 3), (r > 0));
        end
        tv[0].lg = 2'd0;
        tv[1].lg = 2'd0;
        // x0 discard, then pointer advanced past req0.
        tv[6]  = mk(3'b001, 3'b000, 5'd0, 5'd2, 5'd3, 3'b001, 1'b1, 5'd3, 1'b1, 2'd2, 1'b1);
        tv[7]  = mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 1'b1, 2'd0, 1'b0);
        tv[8]  = mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        tv[9]  = mk(3'b101, 3'b000, 5'd1, 5'd2, 5'd9, 3'b100, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        tv[10] = mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd9, 1'b0, 2'd2, 1'b1);
        tv[11] = mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 1'b1, 2'd2, 1'b0);
        // req1 locks for three beats, then drops valid; req2 wins the same cycle.
        tv[12] = mk(3'b010, 3'b010, 5'd1, 5'd4, 5'd3, 3'b010, 1'b0, 5'd0, 1'b0, 2'd2, 1'b0);
        tv[13] = mk(3'b111, 3'b010, 5'd1, 5'd4, 5'd3, 3'b010, 1'b1, 5'd4, 1'b0, 2'd1, 1'b1);
        tv[14] = mk(3'b111, 3'b010, 5'd1, 5'd4, 5'd3, 3'b010, 1'b1, 5'd4, 1'b1, 2'd1, 1'b1);
        tv[15] = mk(3'b101, 3'b000, 5'd1, 5'd2, 5'd6, 3'b100, 1'b1, 5'd4, 1'b1, 2'd1, 1'b1);
        tv[16] = mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd6, 1'b1, 2'd2, 1'b1);
        tv[17] = mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 1'b1, 2'd2, 1'b0);
        // Lock cap: req2 holds 8 beats against a waiting req0, which wins beat 9.
        tv[18] = mk(3'b001, 3'b000, 5'd7, 5'd2, 5'd8, 3'b001, 1'b0, 5'd0, 1'b0, 2'd2, 1'b0);
        tv[19] = mk(3'b101, 3'b100, 5'd7, 5'd2, 5'd8, 3'b100, 1'b1, 5'd7, 1'b0, 2'd0, 1'b1);
        for (int r = 20; r <= 26; r++) begin
            tv[r] = mk(3'b101, 3'b100, 5'd7, 5'd2, 5'd8, 3'b100, 1'b1, 5'd8, 1'b1, 2'd2, 1'b1);
        end
        tv[27] = mk(3'b101, 3'b100, 5'd7, 5'd2, 5'd8, 3'b001, 1'b1, 5'd8, 1'b1, 2'd2, 1'b1);
        tv[28] = mk(3'b101, 3'b100, 5'd7, 5'd2, 5'd8, 3'b100, 1'b1, 5'd7, 1'b1, 2'd0, 1'b1);
        tv[29] = mk(3'b101, 3'b100, 5'd7, 5'd2, 5'd8, 3'b100, 1'b1, 5'd8, 1'b1, 2'd2, 1'b1);

        // Reset state, with requests pending to show ready is held low.
        reset     = 1'b0;
        req_valid = 3'b111;
        req_lock  = 3'b000;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = '0;
        #12;
        chk("rst ready", 64'(req_ready), 64'd0);
        chk("rst wen", 64'(rf_wen), 64'd0);
        chk("rst waddr", 64'(rf_waddr), 64'd0);
        chk("rst wdata", rf_wdata, 64'd0);
        chk("rst snap", 64'(snap_valid), 64'd0);
        chk("rst last_grant", 64'(last_grant), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        req_valid = 3'b000;
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        run_rows(0, 5);
`ifdef GPR_WR_ARB_PERF_EN
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("perf grant%0d", i), 64'(perf_grant_cnt[i*32 +: 32]), 64'd2);
            chk($sformatf("perf stall%0d", i), 64'(perf_stall_cnt[i*32 +: 32]), 64'd4);
        end
`endif
        run_rows(6, NROWS - 1);

        // Asynchronous reset between edges while locked with a write in flight.
        #2;
        chk("pre-rst wen", 64'(rf_wen), 64'd1);
        chk("pre-rst busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("async wen", 64'(rf_wen), 64'd0);
        chk("async snap", 64'(snap_valid), 64'd0);
        chk("async ready", 64'(req_ready), 64'd0);
        chk("async busy", 64'(busy), 64'd0);
        chk("async last_grant", 64'(last_grant), 64'd0);
        @(posedge clock);
        #3;
        req_valid = 3'b111;
        req_lock  = 3'b000;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = '0;
        reset     = 1'b1;
        #1;
        chk("post-rst ready", 64'(req_ready), 64'b001);
        @(posedge clock);
        #1;
        chk("post-rst wen", 64'(rf_wen), 64'd1);
        chk("post-rst waddr", 64'(rf_waddr), 64'd1);
        chk("post-rst last_grant", 64'(last_grant), 64'd0);

        // Single requester req1 writing x5.
        req_valid = 3'b010;
        req_addr  = {5'd3, 5'd5, 5'd1};
        req_data  = {64'd0, 64'hDEAD_BEEF, 64'd0};
        #1;
        chk("single ready", 64'(req_ready), 64'b010);
        @(posedge clock);
        #1;
        req_valid = 3'b000;
        chk("single wen", 64'(rf_wen), 64'd1);
        chk("single waddr", 64'(rf_waddr), 64'd5);
        chk("single wdata", rf_wdata, 64'hDEAD_BEEF);
        chk("single last_grant", 64'(last_grant), 64'd1);
        @(posedge clock);
        #1;
        chk("single snap", 64'(snap_valid), 64'd1);
        chk("single wen drop", 64'(rf_wen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_wr_arbiter.md
Name: gpr_wr_arbiter

Overview:
- Shares the single GPR write port among NREQ requesters: writeback, CSR-to-GPR move and debug/host poke.
- Uses round-robin arbitration with an optional per-requester lock for back-to-back bursts.
- Registers the winning write and drives the regfile one cycle later.
- Emits a one-cycle snapshot strobe after each real write lands, so the difftest GPR export samples only post-commit state.

Parameters:
- NREQ, 3, number of write requesters (2..8); index 0 is highest priority at reset.
- XLEN, 64, GPR data width.
- AW, 5, GPR address width (32 registers).
- LOCK_MAX, 8, maximum consecutive beats a locked requester may hold the grant.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- req_valid  in  NREQ  per-requester write request.
- req_lock  in  NREQ  requester asks to keep the grant for its next beat.
- req_addr  in  NREQ*AW  flattened destination register indices; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*XLEN  flattened write data, same slicing.
- req_ready  out  NREQ  one-hot accept for the current cycle; a beat transfers when valid&&ready.
- rf_wen  out  1  regfile write enable (registered).
- rf_waddr  out  AW  regfile write index (registered).
- rf_wdata  out  XLEN  regfile write data (registered).
- snap_valid  out  1  one-cycle pulse, the cycle after rf_wen, signalling a committed write.
- last_grant  out  $clog2(NREQ)  index of the most recent granted requester (registered).
- busy  out  1  high while in the LOCKED state or while rf_wen is asserted.

Behaviour:
- Reset values:
  - rf_wen, rf_waddr, rf_wdata = 0; snap_valid = 0; last_grant = 0.
  - rr_ptr = 0; lock_cnt = 0; state = IDLE.
  - req_ready = 0 while reset is asserted.
- Arbitration: req_ready is combinational from req_valid, state and rr_ptr. At most one bit is set, and never for a requester whose valid is low.
- IDLE:
  - Grant the first valid requester searching from rr_ptr upward, modulo NREQ.
  - On the granted beat, rr_ptr <= grant+1 (wraps NREQ-1 -> 0).
  - If req_lock of the granted requester is high: go to LOCKED, lock_owner <= grant, lock_cnt <= 1.
- LOCKED:
  - Only lock_owner may receive ready; all other requesters stall.
  - Each transferred beat increments lock_cnt.
  - Exit to IDLE when any of these holds:
    - the owner transfers with req_lock=0;
    - the owner drops req_valid;
    - lock_cnt reaches LOCK_MAX. The beat that reaches LOCK_MAX still transfers; then the state is forced to IDLE and rr_ptr <= owner+1.
- Write pipeline: a transferred beat is registered; rf_wen/rf_waddr/rf_wdata are valid in cycle t+1. With no transfer, rf_wen is 0 in t+1. Throughput is 1 beat/cycle with no bubbles.
- x0 rule: a beat with addr==0 is accepted (ready high, rr_ptr advances) but produces rf_wen=0 and no snap_valid.
- snap_valid = rf_wen delayed one cycle, so it is high in t+2 for a non-x0 beat transferred in t.
- Requesters must hold addr/data stable while valid&&!ready. The block does not check this.
- Reset mid-burst (asynchronous assertion): all state clears immediately, the pending registered write is discarded, and rf_wen drops without waiting for a clock edge.

Optional Feature:
- Macro: GPR_WR_ARB_PERF_EN.
- When defined:
  - Adds output perf_grant_cnt (NREQ*32), counting transferred beats per requester.
  - Adds output perf_stall_cnt (NREQ*32), counting cycles with valid&&!ready per requester.
  - Counters wrap at 2^32 and reset to 0.
- When undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package gpr_pkg holds:
  - GPR_AW=5, GPR_NUM=32, XLEN=64;
  - the arbiter state typedef (IDLE, LOCKED);
  - the gpr_wr_req_t struct (valid, lock, addr, data).
- One sub-module is natural: rr_pick (parameterised round-robin priority picker, taking a request vector and start pointer and returning a one-hot grant plus index). Reuse it in future CSR-port sharing.

Test Plan:
- Single requester: NREQ=3, only req1 valid, addr=5, data=0xDEAD_BEEF -> ready[1] the same cycle; rf_wen=1, waddr=5 next cycle; snap_valid the cycle after; last_grant=1.
- Fairness: all three valid continuously, lock=0, for 6 cycles -> grant order 0,1,2,0,1,2; each perf_grant_cnt=2 when GPR_WR_ARB_PERF_EN is defined.
- Lock cap: req2 valid with lock=1 held for 12 cycles, req0 also valid -> req2 receives 8 consecutive grants (LOCK_MAX); req0 is granted on beat 9; rr_ptr then points to 0->1 ordering.
- x0 discard: req0 writes addr=0, data=0xFFFF -> ready[0]=1, rf_wen stays 0, snap_valid stays 0, rr_ptr advances to 1.
- Async reset mid-lock: assert reset between clock edges while LOCKED with rf_wen=1 -> rf_wen, snap_valid and req_ready drop to 0 immediately; after release, the first grant goes to req0.
- Lock release by valid drop: owner req1 locked for 3 beats, then valid=0 -> the same cycle another valid requester (req2) is granted, state returns to IDLE, busy deasserts once the pipeline drains.
